serial_adder_ctrl: RTL

//  Bit-serial adder controller: sequences a single 1-bit full-adder slice to add two WIDTH-bit operands.
//  The slice is built from two halfadder instances plus an OR gate, and a carry flip-flop holds the carry between bits.

---
 rtl/serial_adder_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice (two half adders + OR) walks WIDTH-bit operands LSB first.
// Define SERIAL_ADDER_SUB_EN to add a SUB input that turns the operation into A-B.

module halfadder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             SUB,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             CO
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE_ST
    } state_t;

    state_t state, state_next;

    logic load, step, finish;

    logic [WIDTH-1:0] op_a, op_b, result_sr;
    logic             carry_ff;
    logic [CW-1:0]    bit_cnt;

    logic slice_b, carry_init;
    logic ha0_sum, ha0_carry, ha1_sum, ha1_carry;
    logic slice_sum, slice_carry;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1: invert B through the slice and seed carry-in with 1.
    logic sub_q;
    assign slice_b    = op_b[0] ^ sub_q;
    assign carry_init = SUB;
`else
    assign slice_b    = op_b[0];
    assign carry_init = 1'b0;
`endif

    halfadder u_ha0 (
        .a     (op_a[0]),
        .b     (slice_b),
        .sum   (ha0_sum),
        .carry (ha0_carry)
    );

    halfadder u_ha1 (
        .a     (ha0_sum),
        .b     (carry_ff),
        .sum   (ha1_sum),
        .carry (ha1_carry)
    );

    assign slice_sum   = ha1_sum;
    assign slice_carry = ha0_carry | ha1_carry;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                BUSY = 1'b1;
                step = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    finish     = 1'b1;
                    state_next = DONE_ST;
                end
            end
            DONE_ST: begin
                BUSY       = 1'b1;
                DONE       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Sum bits enter at the MSB so that after WIDTH shifts the first bit sits at bit 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_a      <= '0;
            op_b      <= '0;
            result_sr <= '0;
            carry_ff  <= 1'b0;
            bit_cnt   <= '0;
            S         <= '0;
            CO        <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else if (load) begin
            op_a      <= A;
            op_b      <= B;
            result_sr <= '0;
            carry_ff  <= carry_init;
            bit_cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q     <= SUB;
`endif
        end else if (step) begin
            op_a      <= op_a >> 1;
            op_b      <= op_b >> 1;
            result_sr <= {slice_sum, result_sr[WIDTH-1:1]};
            carry_ff  <= slice_carry;
            bit_cnt   <= bit_cnt + 1'b1;
            if (finish) begin
                S  <= {slice_sum, result_sr[WIDTH-1:1]};
                CO <= slice_carry;
            end
        end
    end

endmodule
